toggle_burst_ctrl: RTL
======================

// Module: toggle_burst_ctrl
// PURPOSE
//   Controller/sequencer for the counter-based toggle (square-wave) generator.
//   Latches a configuration (half-period, burst length, inter-burst gap, repeat),
//   then on start emits bursts of square-wave periods on tone_out.
//   Sits between the ui_in/uio config pins and the uio_out tone pin in the top level.
//   Replaces the free-running fixed divide-by-65536 toggler with a schedulable one.
// PARAMETERS
//   CNT_W    16  width of half-period and gap counters/config fields
//   BURST_W   8  width of burst-length field and period counter
// PORTS
//   clk              in   1        clock clk
//   rst_n            in   1        reset rst_n, asynchronous, active-high
//   cfg_valid        in   1        config offer; accepted when cfg_valid && cfg_ready
//   cfg_ready        out  1        1 only in IDLE (and not in reset)
//   cfg_half_period  in   CNT_W    cycles per tone half-period; 0 is treated as 1
//   cfg_burst_len    in   BURST_W  periods per burst; 0 = continuous until stop
//   cfg_gap          in   CNT_W    low cycles between bursts / after last burst
//   cfg_repeat       in   1        1 = restart burst after gap; 0 = single burst
//   start            in   1        level-sampled; acted on only in IDLE
//   stop             in   1        abort; highest priority below reset
//   tone_out         out  1        generated square wave
//   busy             out  1        state != IDLE
//   done             out  1        1-cycle pulse on normal (non-stop) completion
//   period_cnt       out  BURST_W  completed periods in current burst
// BEHAVIOUR
//   Reset (rst_n=1, async): state=IDLE, tone_out=0, busy=0, done=0, period_cnt=0,
//     counters=0, cfg_ready=0 while asserted, shadow cfg = hp 1, len 1, gap 0, repeat 0.
//   All outputs registered except cfg_ready, busy (decoded from state).
//   Config: accepted in same edge as cfg_valid&&cfg_ready; new values used on next start.
//     cfg_valid while busy: ignored, shadow regs unchanged.
//   States: IDLE, RUN, GAP.
//   IDLE: tone_out=0. start=1 && stop=0 at edge T -> RUN from T, hcnt=0, period_cnt=0.
//     cfg_valid and start in same IDLE cycle: cfg latched AND used by this start.
//   RUN: hcnt increments each edge; at hcnt==hp-1, hcnt<=0 and tone_out toggles.
//     First rise at edge T+hp; each half-period exactly hp cycles (hp=1 -> clk/2).
//     Each 1->0 toggle increments period_cnt (wraps modulo 2^BURST_W when len=0).
//     At the edge of the len-th 1->0 toggle (len!=0): tone_out=0 and
//       gap!=0 -> GAP (gcnt=0); gap==0 -> RUN restart if repeat, else IDLE.
//   GAP: tone_out held 0; gcnt increments; at gcnt==gap-1 -> RUN (repeat, period_cnt=0,
//     hcnt=0) or IDLE (no repeat). GAP lasts exactly gap cycles.
//   Restart RUN after gap behaves as from start: first rise hp cycles later.
//   done=1 for exactly the first cycle in IDLE after normal completion; never on stop.
//   stop=1 at any edge in RUN/GAP -> IDLE next edge, tone_out=0, period_cnt=0, no done.
//   stop && start in IDLE: stays IDLE. stop beats a same-edge completion (no done).
//   Reset mid-operation: immediate return to reset values, shadow cfg reset too.
//   All counters compare with ==; no overflow possible since hp,gap <= 2^CNT_W-1.
// TESTING
//   hp=3,len=2,gap=0,rep=0; start at edge 0 -> tone 1 after edges 3,9; 0 after 6,12;
//     done=1 only in cycle after edge 12; busy=0 from edge 12; period_cnt 1 then 2.
//   hp=0 (clamped 1),len=4,gap=5,rep=1 -> tone toggles every cycle 8 cycles, 5 low,
//     repeats; stop mid-GAP -> IDLE next edge, done never asserted.
//   len=0,hp=2 -> continuous tone period 4 cycles; period_cnt wraps 255->0; stop ends it.
//   cfg_valid pulsed while busy with hp=9 -> ignored; next burst still uses old hp.
//   start+stop same IDLE cycle -> stays IDLE; stop on edge of final falling toggle -> no done.
//   Assert rst_n mid-RUN (async, between edges) -> tone_out=0, busy=0 immediately; cfg defaults.

Source files
------------

// File: rtl/toggle_burst_ctrl_if.sv
// Bus between the configuration/control side and the toggle burst controller.
// The master modport belongs to whoever configures and starts bursts.
// The slave modport belongs to the controller itself.
interface toggle_burst_ctrl_if #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_half_period;
    logic [BURST_W-1:0] cfg_burst_len;
    logic [CNT_W-1:0]   cfg_gap;
    logic               cfg_repeat;
    logic               start;
    logic               stop;
    logic               tone_out;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] period_cnt;

    modport master (
        output cfg_valid, cfg_half_period, cfg_burst_len, cfg_gap, cfg_repeat,
        output start, stop,
        input  cfg_ready, tone_out, busy, done, period_cnt
    );

    modport slave (
        input  cfg_valid, cfg_half_period, cfg_burst_len, cfg_gap, cfg_repeat,
        input  start, stop,
        output cfg_ready, tone_out, busy, done, period_cnt
    );
endinterface

// File: rtl/toggle_burst_ctrl.sv
// Schedulable square-wave burst generator.
// A configuration (half-period, burst length, gap, repeat) is latched while idle.
// On start it emits bursts of square-wave periods on tone_out, optionally
// repeating after a low gap, until the burst count is reached or stop is raised.
module toggle_burst_ctrl #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    toggle_burst_ctrl_if.slave ctrl_if
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP
    } state_e;

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   hcnt_q, hcnt_d;
    logic [CNT_W-1:0]   gcnt_q, gcnt_d;
    logic [BURST_W-1:0] period_cnt_q, period_cnt_d;
    logic               tone_q, tone_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   hp_q, hp_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic               rep_q, rep_d;

    logic [CNT_W-1:0]   hpEff;
    logic [BURST_W-1:0] periodNext;

    // Next-state logic: config capture in IDLE, half-period timing in RUN, low gap in GAP.
    always_comb begin
        state_d      = state_q;
        hcnt_d       = hcnt_q;
        gcnt_d       = gcnt_q;
        period_cnt_d = period_cnt_q;
        tone_d       = tone_q;
        done_d       = 1'b0;
        hp_d         = hp_q;
        len_d        = len_q;
        gap_d        = gap_q;
        rep_d        = rep_q;
        hpEff        = (hp_q == '0) ? CNT_ONE : hp_q;
        periodNext   = period_cnt_q + BURST_ONE;

        case (state_q)
            IDLE: begin
                tone_d = 1'b0;
                if (ctrl_if.cfg_valid) begin
                    hp_d  = ctrl_if.cfg_half_period;
                    len_d = ctrl_if.cfg_burst_len;
                    gap_d = ctrl_if.cfg_gap;
                    rep_d = ctrl_if.cfg_repeat;
                end
                if (ctrl_if.start && !ctrl_if.stop) begin
                    state_d      = RUN;
                    hcnt_d       = '0;
                    period_cnt_d = '0;
                end
            end
            RUN: begin
                if (ctrl_if.stop) begin
                    state_d      = IDLE;
                    tone_d       = 1'b0;
                    period_cnt_d = '0;
                    hcnt_d       = '0;
                    gcnt_d       = '0;
                end else if (hcnt_q == hpEff - CNT_ONE) begin
                    hcnt_d = '0;
                    if (!tone_q) begin
                        tone_d = 1'b1;
                    end else begin
                        tone_d       = 1'b0;
                        period_cnt_d = periodNext;
                        if ((len_q != '0) && (periodNext == len_q)) begin
                            if (gap_q != '0) begin
                                state_d = GAP;
                                gcnt_d  = '0;
                            end else if (rep_q) begin
                                period_cnt_d = '0;
                            end else begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end else begin
                    hcnt_d = hcnt_q + CNT_ONE;
                end
            end
            GAP: begin
                tone_d = 1'b0;
                if (ctrl_if.stop) begin
                    state_d      = IDLE;
                    period_cnt_d = '0;
                    hcnt_d       = '0;
                    gcnt_d       = '0;
                end else if (gcnt_q == gap_q - CNT_ONE) begin
                    gcnt_d = '0;
                    if (rep_q) begin
                        state_d      = RUN;
                        hcnt_d       = '0;
                        period_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    gcnt_d = gcnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                tone_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset also restores the default shadow configuration.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= IDLE;
            hcnt_q       <= '0;
            gcnt_q       <= '0;
            period_cnt_q <= '0;
            tone_q       <= 1'b0;
            done_q       <= 1'b0;
            hp_q         <= CNT_ONE;
            len_q        <= BURST_ONE;
            gap_q        <= '0;
            rep_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            gcnt_q       <= gcnt_d;
            period_cnt_q <= period_cnt_d;
            tone_q       <= tone_d;
            done_q       <= done_d;
            hp_q         <= hp_d;
            len_q        <= len_d;
            gap_q        <= gap_d;
            rep_q        <= rep_d;
        end
    end

    assign ctrl_if.cfg_ready  = (state_q == IDLE) && !rst_n;
    assign ctrl_if.busy       = (state_q != IDLE);
    assign ctrl_if.tone_out   = tone_q;
    assign ctrl_if.done       = done_q;
    assign ctrl_if.period_cnt = period_cnt_q;

endmodule
